crc_frame_feeder: RTL and testbench
===================================

# crc_frame_feeder

Frame-buffering byte source that sits directly upstream of the pipelined CRC-8 checker. It accepts a host byte stream with valid/ready handshaking and stores one complete frame. It then replays the frame to the CRC checker as a gap-free burst with first/last/valid framing, followed by zero-byte flush cycles that drain the checker pipeline. It waits for the checker's done, then tallies the pass/fail result.

## Interface
- DEPTH, 16: frame buffer depth in bytes; power of 2, ≥2; maximum frame length.
- FLUSH_CYCLES, 9: zero-data valid cycles driven after the last byte; ≥1.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host byte valid.
- in_ready  out  1  feeder can accept a byte.
- in_data  in  8  host byte.
- in_last  in  1  final byte of host frame.
- out_valid  out  1  byte valid to CRC checker (its valid).
- out_first  out  1  first frame byte (its first).
- out_last  out  1  last frame byte (its last).
- out_data  out  8  byte to CRC checker (its data).
- crc_done  in  1  checker done.
- crc_pass  in  1  checker pass; sampled only with crc_done.
- busy  out  1  high in SEND, FLUSH, WAIT_DONE.
- err_oversize  out  1  one-cycle pulse: frame exceeded DEPTH and was dropped.
- frame_count  out  8  frames completed; wraps 255→0.
- fail_count  out  8  frames completed with crc_pass=0; wraps 255→0.

## Operation
- States: FILL, DROP, SEND, FLUSH, WAIT_DONE. Reset state is FILL.
- Byte accept occurs when in_valid && in_ready.
- in_ready = 1 in FILL and DROP, 0 otherwise. It is registered, so it is 0 during reset.
- FILL:
  - Each accept writes mem[wr_ptr], then increments wr_ptr and len. len is $clog2(DEPTH)+1 bits.
  - Accept with in_last=1: go to SEND with rd_ptr=0.
  - Accept of the DEPTH-th byte with in_last=0: pulse err_oversize, clear len/wr_ptr, go to DROP.
  - A DEPTH-th byte with in_last=1 is a legal full frame and goes to SEND.
- DROP: accepted bytes are discarded. An accept with in_last=1 goes to FILL with len=0.
- SEND:
  - Each cycle: out_valid=1, out_data=mem[rd_ptr], rd_ptr++.
  - out_first=1 only when rd_ptr=0. out_last=1 only when rd_ptr=len-1.
  - A 1-byte frame asserts out_first and out_last together.
  - The checker has no backpressure.
  - After the last byte, go to FLUSH with flush counter = 0.
- FLUSH: out_valid=1, out_data=8'h00, out_first=out_last=0 for exactly FLUSH_CYCLES cycles, then go to WAIT_DONE.
- WAIT_DONE:
  - out_valid=0; waits indefinitely.
  - First cycle with crc_done=1: frame_count++; fail_count++ if crc_pass=0; clear wr_ptr/len; go to FILL.
- crc_done/crc_pass are ignored outside WAIT_DONE.
- out_data is 8'h00 whenever out_valid=0.

## Timing
- All outputs are registered. Reset values: in_ready=0, out_valid=0, out_first=0, out_last=0, out_data=0, busy=0, err_oversize=0, frame_count=0, fail_count=0.
- rst_n low clears everything asynchronously, at any state including mid-SEND/FLUSH. out_valid drops immediately. Buffer contents are don't-care.
- in_ready rises on the first posedge after rst_n deasserts.
- Final byte (in_last) accepted at edge T:
  - in_ready=0 and busy=1 from T.
  - Byte k (0-based) of an N-byte frame is on out_* during cycle T+1+k.
  - Flush covers cycles T+N+1 … T+N+FLUSH_CYCLES.
  - out_valid=0 from T+N+FLUSH_CYCLES+1.
- crc_done high at edge D in WAIT_DONE:
  - Counters update at D.
  - in_ready=1 and busy=0 after D.
  - The first byte of the next frame is accepted no earlier than D+1.
- err_oversize is high for exactly the cycle after the offending accept. in_ready stays 1 across the FILL→DROP transition.

## Test plan
- 3-byte frame 8'h31, 8'h32, 8'h33 with in_last on the third byte → one cycle each: out_first=1 with 8'h31, nothing with 8'h32, out_last=1 with 8'h33. Then 9 cycles of out_valid=1 with data 00, then out_valid=0. crc_done=1, crc_pass=1 → frame_count=1, fail_count=0, in_ready=1.
- 1-byte frame 8'hA5 → single cycle with out_first=out_last=out_valid=1 and data A5, then 9 flush cycles. crc_done with crc_pass=0 → fail_count=1.
- DEPTH=16; 16 bytes with in_last on the 16th → full 16-byte burst, no err_oversize. 17-byte frame → err_oversize one pulse after byte 16, remaining byte dropped, out_valid never asserted, frame_count unchanged.
- crc_done toggled high during FILL/SEND/FLUSH → no counter change. Hold crc_done low 100 cycles in WAIT_DONE → in_ready stays 0, out_valid stays 0.
- rst_n pulsed low mid-SEND of a 5-byte frame → out_valid=0 and counters=0 immediately. in_ready=1 one edge after release. A new 2-byte frame is sent correctly.
- 256 back-to-back passing frames → frame_count wraps to 0.

Source files
------------

// File: rtl/crc_frame_feeder.sv
// rtl/crc_frame_feeder.sv - frame buffer that replays one host frame as a burst to the CRC-8 checker
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     host byte handshake; in_data byte, in_last ends the frame
//   out_valid/out_first/  burst to the CRC checker (no backpressure); frame bytes
//   out_last/out_data     followed by FLUSH_CYCLES zero bytes
//   crc_done/crc_pass     checker verdict, honoured only while waiting for it
//   busy                  frame in flight (SEND, FLUSH, WAIT_DONE)
//   err_oversize          one-cycle pulse when a frame longer than DEPTH is dropped
//   frame_count           frames completed (wrapping)
//   fail_count            frames completed with a failing CRC (wrapping)
module crc_frame_feeder #(
    parameter int DEPTH        = 16,
    parameter int FLUSH_CYCLES = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last,
    output logic [7:0] out_data,
    input  logic       crc_done,
    input  logic       crc_pass,
    output logic       busy,
    output logic       err_oversize,
    output logic [7:0] frame_count,
    output logic [7:0] fail_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_FILL,
        S_DROP,
        S_SEND,
        S_FLUSH,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] len;
    logic [FW-1:0] flush_cnt;

    logic accept;
    logic full_hit;
    logic send_last;
    logic flush_end;

    logic       in_ready_d;
    logic       busy_d;
    logic       out_valid_d;
    logic       out_first_d;
    logic       out_last_d;
    logic [7:0] out_data_d;
    logic       err_d;

    assign accept    = in_valid && in_ready;
    // The byte being accepted now would be the DEPTH-th one.
    assign full_hit  = (len == LW'(DEPTH - 1));
    assign send_last = ({1'b0, rd_ptr} == (len - LW'(1)));
    assign flush_end = (flush_cnt == FW'(FLUSH_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: begin
                if (accept) begin
                    if (in_last) begin
                        state_nxt = S_SEND;
                    end else if (full_hit) begin
                        state_nxt = S_DROP;
                    end
                end
            end
            S_DROP:  if (accept && in_last) state_nxt = S_FILL;
            S_SEND:  if (send_last) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_end) state_nxt = S_WAIT;
            S_WAIT:  if (crc_done) state_nxt = S_FILL;
            default: state_nxt = S_FILL;
        endcase
    end

    // Output logic: values computed here are registered below, so the
    // handshake/status outputs are derived from the state being entered.
    always_comb begin
        in_ready_d  = (state_nxt == S_FILL) || (state_nxt == S_DROP);
        busy_d      = (state_nxt == S_SEND) || (state_nxt == S_FLUSH) || (state_nxt == S_WAIT);
        out_valid_d = (state == S_SEND) || (state == S_FLUSH);
        out_data_d  = (state == S_SEND) ? mem[rd_ptr] : 8'h00;
        out_first_d = (state == S_SEND) && (rd_ptr == '0);
        out_last_d  = (state == S_SEND) && send_last;
        err_d       = (state == S_FILL) && accept && !in_last && full_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= 8'h00;
            err_oversize <= 1'b0;
        end else begin
            in_ready     <= in_ready_d;
            busy         <= busy_d;
            out_valid    <= out_valid_d;
            out_first    <= out_first_d;
            out_last     <= out_last_d;
            out_data     <= out_data_d;
            err_oversize <= err_d;
        end
    end

    // Frame buffer: contents need no reset, len bounds what is replayed.
    always_ff @(posedge clk) begin
        if ((state == S_FILL) && accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, flush counter and result tallies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            len         <= '0;
            flush_cnt   <= '0;
            frame_count <= 8'h00;
            fail_count  <= 8'h00;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (!in_last && full_hit) begin
                            wr_ptr <= '0;
                            len    <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                            len    <= len + LW'(1);
                        end
                        if (in_last) begin
                            rd_ptr <= '0;
                        end
                    end
                end
                S_DROP: begin
                    if (accept && in_last) begin
                        wr_ptr <= '0;
                        len    <= '0;
                    end
                end
                S_SEND: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    if (send_last) begin
                        flush_cnt <= '0;
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt + FW'(1);
                end
                S_WAIT: begin
                    if (crc_done) begin
                        frame_count <= frame_count + 8'd1;
                        if (!crc_pass) begin
                            fail_count <= fail_count + 8'd1;
                        end
                        wr_ptr <= '0;
                        len    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_feeder.sv
// tb/tb_crc_frame_feeder.sv - scoreboard bench for crc_frame_feeder
module tb_crc_frame_feeder;

    localparam int DEPTH = 16;
    localparam int FLUSH = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_first;
    logic       out_last;
    logic [7:0] out_data;
    logic       crc_done = 1'b0;
    logic       crc_pass = 1'b0;
    logic       busy;
    logic       err_oversize;
    logic [7:0] frame_count;
    logic [7:0] fail_count;

    crc_frame_feeder #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last), .out_data(out_data),
        .crc_done(crc_done), .crc_pass(crc_pass), .busy(busy), .err_oversize(err_oversize),
        .frame_count(frame_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef logic [7:0] bq_t[$];

    beat_t exp_q[$];
    beat_t mon_beat;
    logic  in_burst = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    exp_frames = 0;
    int    exp_fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid beat must match the head of the scoreboard, and a
    // burst, once started, must run without gaps until the queue is empty.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {out_first, out_last, out_data}, 32'h0);
                    check("unexpected_valid", out_valid, 1'b0);
                end else begin
                    mon_beat = exp_q.pop_front();
                    check("beat", {out_first, out_last, out_data},
                          {mon_beat.first, mon_beat.last, mon_beat.data});
                    in_burst = (exp_q.size() != 0);
                end
            end else begin
                if (in_burst) begin
                    check("burst_gap", out_valid, 1'b1);
                    in_burst = 1'b0;
                end
                check("idle_data_zero", out_data, 8'h00);
            end
        end
    end

    task automatic send_bytes(input bq_t b, input logic last_on_final);
        int n;
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = last_on_final && (i == b.size() - 1);
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic push_frame(input bq_t b);
        for (int i = 0; i < b.size(); i++) begin
            exp_q.push_back('{first: (i == 0), last: (i == b.size() - 1), data: b[i]});
        end
        for (int i = 0; i < FLUSH; i++) begin
            exp_q.push_back('{first: 1'b0, last: 1'b0, data: 8'h00});
        end
    endtask

    // Wait for the scoreboard to empty; optionally wiggle crc_done while the
    // burst is still running (it must be ignored outside WAIT_DONE).
    task automatic drain(input logic toggle_done);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            crc_pass = 1'b0;
            crc_done = (toggle_done && exp_q.size() >= 2) ? ~crc_done : 1'b0;
            n++;
        end
        crc_done = 1'b0;
        check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        check("post_flush_valid", out_valid, 1'b0);
        check("post_flush_busy", busy, 1'b1);
        check("post_flush_ready", in_ready, 1'b0);
    endtask

    task automatic send_frame(input bq_t b, input logic toggle_done);
        push_frame(b);
        send_bytes(b, 1'b1);
        check("last_accept_ready", in_ready, 1'b0);
        check("last_accept_busy", busy, 1'b1);
        check("last_accept_valid", out_valid, 1'b0);
        @(negedge clk);
        check("first_byte_latency", {out_valid, out_first}, 2'b11);
        drain(toggle_done);
    endtask

    task automatic complete(input logic pass);
        @(negedge clk);
        crc_done = 1'b1;
        crc_pass = pass;
        @(posedge clk);
        @(negedge clk);
        crc_done = 1'b0;
        crc_pass = 1'b0;
        exp_frames = (exp_frames + 1) % 256;
        if (!pass) exp_fails = (exp_fails + 1) % 256;
        check("frame_count", frame_count, exp_frames[7:0]);
        check("fail_count", fail_count, exp_fails[7:0]);
        check("done_ready", in_ready, 1'b1);
        check("done_busy", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bq_t b;
        int bad;

        // Reset state
        #12;
        check("rst_ready", in_ready, 1'b0);
        check("rst_outs", {out_valid, out_first, out_last, out_data}, 32'h0);
        check("rst_status", {busy, err_oversize}, 2'b00);
        check("rst_counts", {frame_count, fail_count}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_in_release_cycle", in_ready, 1'b0);
        @(negedge clk);
        check("ready_after_release", in_ready, 1'b1);

        // 3-byte frame, passing
        b = '{8'h31, 8'h32, 8'h33};
        send_frame(b, 1'b0);
        complete(1'b1);

        // 1-byte frame, failing
        b = '{8'hA5};
        send_frame(b, 1'b0);
        complete(1'b0);

        // Full DEPTH frame is legal
        b = {};
        for (int i = 0; i < DEPTH; i++) b.push_back(8'(8'h40 + i));
        send_frame(b, 1'b0);
        check("full_no_err", err_oversize, 1'b0);
        complete(1'b1);

        // Oversize frame: DEPTH bytes without last, then one more with last
        b = {};
        for (int i = 0; i < DEPTH; i++) b.push_back(8'(8'h80 + i));
        send_bytes(b, 1'b0);
        check("oversize_pulse", err_oversize, 1'b1);
        check("oversize_ready", in_ready, 1'b1);
        b = '{8'hEE};
        send_bytes(b, 1'b1);
        check("oversize_pulse_gone", err_oversize, 1'b0);
        check("drop_back_to_fill", {in_ready, busy}, 2'b10);
        repeat (3) @(negedge clk);
        check("oversize_frames", frame_count, exp_frames[7:0]);

        // crc_done during FILL is ignored
        @(negedge clk);
        crc_done = 1'b1;
        crc_pass = 1'b0;
        repeat (2) @(negedge clk);
        crc_done = 1'b0;
        check("fill_done_ignored", {frame_count, fail_count}, {exp_frames[7:0], exp_fails[7:0]});

        // crc_done toggled during SEND/FLUSH is ignored; WAIT_DONE holds
        b = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_frame(b, 1'b1);
        check("send_done_ignored", {frame_count, fail_count}, {exp_frames[7:0], exp_fails[7:0]});
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("wait_hold", bad, 0);
        complete(1'b1);

        // Reset in the middle of SEND
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        push_frame(b);
        send_bytes(b, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        in_burst = 1'b0;
        exp_frames = 0;
        exp_fails = 0;
        #1;
        check("midsend_rst_valid", {out_valid, out_first, out_last, out_data}, 32'h0);
        check("midsend_rst_counts", {frame_count, fail_count}, 16'h0);
        check("midsend_rst_status", {in_ready, busy}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        check("midsend_release_ready", in_ready, 1'b0);
        @(negedge clk);
        check("midsend_ready_after", in_ready, 1'b1);
        b = '{8'hC3, 8'h3C};
        send_frame(b, 1'b0);
        complete(1'b1);

        // 256 back-to-back passing frames: frame_count wraps through 0
        for (int f = 0; f < 256; f++) begin
            b = '{8'(f)};
            send_frame(b, 1'b0);
            complete(1'b1);
        end
        check("wrap_final", frame_count, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
